// File: rtl/batch_admitter_pkg.sv
// Shared types and default sizing for the batch admitter.
package batch_admitter_pkg;

    localparam int unsigned DEF_DEPS        = 4;
    localparam int unsigned DEF_KEY_W       = 64;
    localparam int unsigned DEF_TABLE_DEPTH = 64;
    localparam int unsigned DEF_MAX_TXN     = 16;
    localparam int unsigned ID_W            = 64;
    // Table entries store keys at the widest supported width; narrower keys are zero-extended.
    localparam int unsigned KEY_MAX_W       = 64;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        REJECT,
        COMMIT,
        ACCEPT,
        SEAL
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_write;
        logic [KEY_MAX_W-1:0] key;
        logic [ID_W-1:0]      owner;
    } entry_t;

endpackage

// File: rtl/batch_admitter_key_table_cam.sv
// Parallel key match against the batch table with lowest-index priority.
module key_table_cam
    import batch_admitter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_TABLE_DEPTH,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  entry_t                entries [DEPTH],
    input  logic [KEY_MAX_W-1:0]  key,
    input  logic                  probe_write,
    output logic                  hit,
    output logic [IDX_W-1:0]      hit_index,
    output logic [ID_W-1:0]       hit_owner
);

    // Descending walk so the lowest matching index is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_index = '0;
        hit_owner = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (entries[i].valid && (key != '0) && (entries[i].key == key) &&
                (probe_write || entries[i].is_write)) begin
                hit       = 1'b1;
                hit_index = IDX_W'(i);
                hit_owner = entries[i].owner;
            end
        end
    end

endmodule

// File: rtl/batch_admitter.sv
// Admits transactions into a batch only when their key sets do not collide
// with transactions already admitted; seals the batch when full or on request.
module batch_admitter
    import batch_admitter_pkg::*;
#(
    parameter int unsigned DEPS        = DEF_DEPS,
    parameter int unsigned KEY_W       = DEF_KEY_W,
    parameter int unsigned TABLE_DEPTH = DEF_TABLE_DEPTH,
    parameter int unsigned MAX_TXN     = DEF_MAX_TXN
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           txn_valid,
    input  logic [ID_W-1:0]                txn_id,
    input  logic [DEPS*KEY_W-1:0]          read_keys,
    input  logic [DEPS*KEY_W-1:0]          write_keys,
    output logic                           pipeline_ready,
    output logic                           accept_valid,
    output logic [ID_W-1:0]                accepted_id,
    output logic                           has_conflict,
    output logic [ID_W-1:0]                conflicting_id,
    input  logic                           batch_seal,
    output logic                           batch_valid,
    input  logic                           batch_ready,
    output logic [$clog2(MAX_TXN+1)-1:0]   batch_count
);

    localparam int unsigned SLOTS  = 2 * DEPS;
    localparam int unsigned SCAN_W = $clog2(SLOTS);
    localparam int unsigned CNT_W  = $clog2(MAX_TXN + 1);
    localparam int unsigned FILL_W = $clog2(TABLE_DEPTH + 1);
    localparam int unsigned TIDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SLOTS - 1);

    state_t                  state_q, state_d;
    logic [ID_W-1:0]         id_q;
    logic [DEPS*KEY_W-1:0]   rk_q, wk_q;
    logic [SCAN_W-1:0]       scan_q;
    logic [FILL_W-1:0]       fill_q;
    logic                    seal_pend_q;
    entry_t                  table_q [TABLE_DEPTH];

    logic [KEY_W-1:0]        slot_keys [SLOTS];
    logic [KEY_MAX_W-1:0]    probe_key;
    logic                    probe_write;
    logic                    cam_hit;
    logic [TIDX_W-1:0]       cam_idx;
    logic [ID_W-1:0]         cam_owner;
    logic                    unused_cam_idx;
    logic                    seal_req;
    logic                    batch_nonempty;
    logic                    batch_full;
    logic                    table_low;

    assign pipeline_ready = (state_q == IDLE);
    assign seal_req       = batch_seal | seal_pend_q;
    assign batch_nonempty = (batch_count != '0);
    assign batch_full     = (batch_count == CNT_W'(MAX_TXN));
    assign table_low      = (FILL_W'(TABLE_DEPTH) - fill_q) < FILL_W'(SLOTS);
    assign unused_cam_idx = ^cam_idx;

    // Flatten the latched key sets into scan order: reads first, then writes.
    always_comb begin
        for (int i = 0; i < int'(DEPS); i++) begin
            slot_keys[i]             = rk_q[i*KEY_W +: KEY_W];
            slot_keys[i + int'(DEPS)] = wk_q[i*KEY_W +: KEY_W];
        end
        probe_key   = KEY_MAX_W'(slot_keys[scan_q]);
        probe_write = (scan_q >= SCAN_W'(DEPS));
    end

    key_table_cam #(
        .DEPTH (TABLE_DEPTH),
        .IDX_W (TIDX_W)
    ) u_cam (
        .entries     (table_q),
        .key         (probe_key),
        .probe_write (probe_write),
        .hit         (cam_hit),
        .hit_index   (cam_idx),
        .hit_owner   (cam_owner)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (txn_valid) begin
                    state_d = CHECK;
                end else if (seal_req && batch_nonempty) begin
                    state_d = SEAL;
                end
            end
            CHECK: begin
                if (cam_hit) begin
                    state_d = REJECT;
                end else if (scan_q == SCAN_LAST) begin
                    state_d = COMMIT;
                end
            end
            REJECT:  state_d = IDLE;
            COMMIT: begin
                if (scan_q == SCAN_LAST) begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT:  state_d = (batch_full || table_low) ? SEAL : IDLE;
            SEAL: begin
                if (batch_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: transaction latch, scan pointer, table updates and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q           <= '0;
            rk_q           <= '0;
            wk_q           <= '0;
            scan_q         <= '0;
            fill_q         <= '0;
            seal_pend_q    <= 1'b0;
            batch_count    <= '0;
            accept_valid   <= 1'b0;
            has_conflict   <= 1'b0;
            batch_valid    <= 1'b0;
            accepted_id    <= '0;
            conflicting_id <= '0;
            for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
                table_q[i] <= '0;
            end
        end else begin
            accept_valid <= (state_d == ACCEPT);
            has_conflict <= (state_d == REJECT);
            batch_valid  <= (state_d == SEAL);

            // A seal request outside IDLE waits; in IDLE it is consumed, ignored on an
            // empty batch, or kept waiting if a transaction is captured in the same cycle.
            if (state_q == IDLE) begin
                seal_pend_q <= txn_valid && seal_req && batch_nonempty;
            end else begin
                seal_pend_q <= seal_pend_q | batch_seal;
            end

            case (state_q)
                IDLE: begin
                    scan_q <= '0;
                    if (txn_valid) begin
                        id_q <= txn_id;
                        rk_q <= read_keys;
                        wk_q <= write_keys;
                    end
                end
                CHECK: begin
                    if (cam_hit) begin
                        conflicting_id <= cam_owner;
                    end else begin
                        scan_q <= (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
                    end
                end
                COMMIT: begin
                    if (probe_key != '0) begin
                        table_q[TIDX_W'(fill_q)] <= '{valid: 1'b1, is_write: probe_write,
                                                     key: probe_key, owner: id_q};
                        fill_q <= fill_q + FILL_W'(1);
                    end
                    if (scan_q == SCAN_LAST) begin
                        scan_q      <= '0;
                        batch_count <= batch_count + CNT_W'(1);
                        accepted_id <= id_q;
                    end else begin
                        scan_q <= scan_q + SCAN_W'(1);
                    end
                end
                SEAL: begin
                    if (batch_ready) begin
                        batch_count <= '0;
                        fill_q      <= '0;
                        for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
                            table_q[i].valid <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_batch_admitter.sv
// Directed bench for batch_admitter with default parameters (DEPS=4, 64-bit keys).
module tb_batch_admitter;

    localparam int unsigned KW = 4 * 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          txn_valid;
    logic [63:0]   txn_id;
    logic [KW-1:0] read_keys;
    logic [KW-1:0] write_keys;
    logic          pipeline_ready;
    logic          accept_valid;
    logic [63:0]   accepted_id;
    logic          has_conflict;
    logic [63:0]   conflicting_id;
    logic          batch_seal;
    logic          batch_valid;
    logic          batch_ready;
    logic [4:0]    batch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    batch_admitter dut (
        .clk            (clk),
        .rst            (rst),
        .txn_valid      (txn_valid),
        .txn_id         (txn_id),
        .read_keys      (read_keys),
        .write_keys     (write_keys),
        .pipeline_ready (pipeline_ready),
        .accept_valid   (accept_valid),
        .accepted_id    (accepted_id),
        .has_conflict   (has_conflict),
        .conflicting_id (conflicting_id),
        .batch_seal     (batch_seal),
        .batch_valid    (batch_valid),
        .batch_ready    (batch_ready),
        .batch_count    (batch_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one transaction from a negedge and return at the negedge of its
    // accept/conflict pulse; lat counts cycles after the capture cycle.
    task automatic offer(input logic [63:0] id, input logic [KW-1:0] rk, input logic [KW-1:0] wk,
                         input int seal_cyc, output int lat, output logic acc);
        int n;
        n = 0;
        while (pipeline_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        txn_valid  = 1'b1;
        txn_id     = id;
        read_keys  = rk;
        write_keys = wk;
        @(negedge clk);
        txn_valid  = 1'b0;
        read_keys  = '0;
        write_keys = '0;
        lat = 1;
        while (!(accept_valid === 1'b1 || has_conflict === 1'b1) && lat < 60) begin
            batch_seal = (lat == seal_cyc);
            @(negedge clk);
            lat++;
        end
        batch_seal = 1'b0;
        acc = accept_valid;
    endtask

    initial begin
        int          lat;
        logic        acc;
        logic        saw_acc;
        logic [KW-1:0] rk, wk;

        rst         = 1'b1;
        txn_valid   = 1'b0;
        txn_id      = '0;
        read_keys   = '0;
        write_keys  = '0;
        batch_seal  = 1'b0;
        batch_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ready",     64'(pipeline_ready), 64'd1);
        chk("rst_acc",       64'(accept_valid),   64'd0);
        chk("rst_conf",      64'(has_conflict),   64'd0);
        chk("rst_bvalid",    64'(batch_valid),    64'd0);
        chk("rst_acc_id",    accepted_id,         64'd0);
        chk("rst_conf_id",   conflicting_id,      64'd0);
        chk("rst_count",     64'(batch_count),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Txn A: R{0x10} W{0x20} on empty batch
        offer(64'hA, KW'(64'h10), KW'(64'h20), 0, lat, acc);
        chk("a_lat",   64'(lat), 64'd17);
        chk("a_acc",   64'(acc), 64'd1);
        chk("a_id",    accepted_id, 64'hA);
        chk("a_count", 64'(batch_count), 64'd1);
        @(negedge clk);
        chk("a_pulse_end", 64'(accept_valid), 64'd0);
        chk("a_id_hold",   accepted_id, 64'hA);

        // Txn B: R{0x20} hits A's write on the first key
        offer(64'hB, KW'(64'h20), '0, 0, lat, acc);
        chk("b_lat",     64'(lat), 64'd2);
        chk("b_conf",    64'(has_conflict), 64'd1);
        chk("b_acc",     64'(acc), 64'd0);
        chk("b_conf_id", conflicting_id, 64'hA);
        chk("b_count",   64'(batch_count), 64'd1);
        @(negedge clk);
        chk("b_pulse_end",  64'(has_conflict), 64'd0);
        chk("b_conf_hold",  conflicting_id, 64'hA);

        // Txn C: R{0x10} read-read with A
        offer(64'hC, KW'(64'h10), '0, 0, lat, acc);
        chk("c_lat",   64'(lat), 64'd17);
        chk("c_acc",   64'(acc), 64'd1);
        chk("c_id",    accepted_id, 64'hC);
        chk("c_count", 64'(batch_count), 64'd2);

        // Txn E: W{0x10} hits A (idx 0) and C; write slot 0 scanned in cycle 5
        offer(64'hE, '0, KW'(64'h10), 0, lat, acc);
        chk("e_lat",     64'(lat), 64'd6);
        chk("e_conf",    64'(has_conflict), 64'd1);
        chk("e_conf_id", conflicting_id, 64'hA);
        chk("e_count",   64'(batch_count), 64'd2);
        chk("e_acc_id_hold", accepted_id, 64'hC);

        // Txn F: duplicate keys inside one transaction do not conflict
        rk = '0; rk[63:0] = 64'h30;
        wk = '0; wk[63:0] = 64'h30; wk[127:64] = 64'h30;
        offer(64'hF, rk, wk, 0, lat, acc);
        chk("f_acc",   64'(acc), 64'd1);
        chk("f_count", 64'(batch_count), 64'd3);

        // Txn D: seal requested during CHECK; D completes, IDLE once, then SEAL
        offer(64'hD, KW'(64'h50), '0, 3, lat, acc);
        chk("d_lat",   64'(lat), 64'd17);
        chk("d_acc",   64'(acc), 64'd1);
        chk("d_count", 64'(batch_count), 64'd4);
        @(negedge clk);
        chk("d_idle_ready",  64'(pipeline_ready), 64'd1);
        chk("d_idle_bvalid", 64'(batch_valid), 64'd0);
        @(negedge clk);
        chk("d_seal_bvalid", 64'(batch_valid), 64'd1);
        chk("d_seal_count",  64'(batch_count), 64'd4);
        chk("d_seal_ready",  64'(pipeline_ready), 64'd0);
        @(negedge clk);
        chk("d_seal_hold",   64'(batch_valid), 64'd1);
        batch_ready = 1'b1;
        @(negedge clk);
        batch_ready = 1'b0;
        chk("d_drain_bvalid", 64'(batch_valid), 64'd0);
        chk("d_drain_count",  64'(batch_count), 64'd0);
        chk("d_drain_ready",  64'(pipeline_ready), 64'd1);

        // Seal on an empty batch is ignored
        batch_seal = 1'b1;
        @(negedge clk);
        batch_seal = 1'b0;
        repeat (3) @(negedge clk);
        chk("empty_seal_bvalid", 64'(batch_valid), 64'd0);
        chk("empty_seal_ready",  64'(pipeline_ready), 64'd1);

        // 16 disjoint single-key transactions fill the batch by count
        for (int t = 0; t < 16; t++) begin
            offer(64'h100 + 64'(t), '0, KW'(64'h100 + 64'(t)), 0, lat, acc);
            chk($sformatf("fill16_acc_%0d", t), 64'(acc), 64'd1);
            chk($sformatf("fill16_cnt_%0d", t), 64'(batch_count), 64'(t + 1));
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("full_bvalid_%0d", c), 64'(batch_valid), 64'd1);
            chk($sformatf("full_count_%0d", c),  64'(batch_count), 64'd16);
        end
        batch_ready = 1'b1;
        @(negedge clk);
        batch_ready = 1'b0;
        chk("full_drain_bvalid", 64'(batch_valid), 64'd0);
        chk("full_drain_count",  64'(batch_count), 64'd0);
        chk("full_drain_ready",  64'(pipeline_ready), 64'd1);

        // Key written in the drained batch is admissible again
        offer(64'h77, '0, KW'(64'h100), 0, lat, acc);
        chk("readmit_acc",   64'(acc), 64'd1);
        chk("readmit_count", 64'(batch_count), 64'd1);
        @(negedge clk);
        batch_seal = 1'b1;
        @(negedge clk);
        batch_seal = 1'b0;
        chk("readmit_seal", 64'(batch_valid), 64'd1);
        batch_ready = 1'b1;
        @(negedge clk);
        batch_ready = 1'b0;

        // Eight full 8-key transactions exhaust the 64-entry table
        for (int t = 0; t < 8; t++) begin
            for (int s = 0; s < 4; s++) begin
                rk[s*64 +: 64] = 64'h1000 + 64'(t * 16 + s);
                wk[s*64 +: 64] = 64'h1000 + 64'(t * 16 + 8 + s);
            end
            offer(64'h200 + 64'(t), rk, wk, 0, lat, acc);
            chk($sformatf("tbl_acc_%0d", t), 64'(acc), 64'd1);
            @(negedge clk);
            chk($sformatf("tbl_bvalid_%0d", t), 64'(batch_valid), (t == 7) ? 64'd1 : 64'd0);
        end
        chk("tbl_count", 64'(batch_count), 64'd8);
        batch_ready = 1'b1;
        @(negedge clk);
        batch_ready = 1'b0;
        chk("tbl_drain_count", 64'(batch_count), 64'd0);

        // Reset during COMMIT discards the transaction and the table
        offer(64'h88, '0, KW'(64'h300), 0, lat, acc);
        chk("pre_rst_acc", 64'(acc), 64'd1);
        @(negedge clk);
        txn_valid = 1'b1;
        txn_id    = 64'h99;
        read_keys = KW'(64'h400);
        @(negedge clk);
        txn_valid = 1'b0;
        read_keys = '0;
        saw_acc   = 1'b0;
        for (int c = 1; c < 12; c++) begin
            saw_acc = saw_acc | accept_valid;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_count", 64'(batch_count), 64'd0);
        chk("mid_rst_ready", 64'(pipeline_ready), 64'd1);
        for (int c = 0; c < 10; c++) begin
            saw_acc = saw_acc | accept_valid;
            @(negedge clk);
        end
        chk("mid_rst_no_accept", 64'(saw_acc), 64'd0);
        chk("mid_rst_acc_id",    accepted_id, 64'd0);
        offer(64'hAA, KW'(64'h300), '0, 0, lat, acc);
        chk("post_rst_acc",   64'(acc), 64'd1);
        chk("post_rst_id",    accepted_id, 64'hAA);
        chk("post_rst_count", 64'(batch_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/batch_admitter.md
BATCH_ADMITTER -- requirements
Module: batch_admitter

Interface
REQ-001 SHALL have parameter DEPS, default 4, giving the number of read keys and the number of write keys per transaction.
REQ-002 SHALL have parameter KEY_W, default 64, giving the account key width; key value 0 means an unused slot.
REQ-003 SHALL have parameter TABLE_DEPTH, default 64, giving the number of key-table entries per batch.
REQ-004 SHALL have parameter MAX_TXN, default 16, giving the maximum number of transactions per batch.
REQ-005 SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- txn_valid  in  1  transaction offered (the forwarder's strobe).
- txn_id  in  64  owner program ID.
- read_keys  in  DEPS*KEY_W  read set; slot i is bits [i*KEY_W +: KEY_W].
- write_keys  in  DEPS*KEY_W  write set, same packing.
- pipeline_ready  out  1  admitter can capture a transaction this cycle.
- accept_valid  out  1  one-cycle pulse: transaction admitted.
- accepted_id  out  64  ID of the admitted transaction.
- has_conflict  out  1  one-cycle pulse: transaction rejected.
- conflicting_id  out  64  batch owner of the first conflicting key.
- batch_seal  in  1  request to close the current batch early.
- batch_valid  out  1  sealed batch offered downstream.
- batch_ready  in  1  downstream takes the sealed batch.
- batch_count  out  $clog2(MAX_TXN+1)  transactions in the current or sealed batch.

Function
REQ-006 SHALL implement the FSM states IDLE, CHECK, REJECT, COMMIT, ACCEPT and SEAL.
REQ-007 SHALL assert pipeline_ready only in IDLE; pipeline_ready SHALL be combinational from state.
REQ-008 IDLE: txn_valid=1 while pipeline_ready=1 SHALL latch txn_id and both key sets and go to CHECK next cycle.
REQ-009 CHECK SHALL scan one key per cycle: read slots 0..DEPS-1, then write slots 0..DEPS-1; zero keys still use their cycle.
REQ-010 Each scanned key SHALL be compared in parallel against all valid table entries.
REQ-011 A conflict SHALL be: a read key matching a table entry marked write, or a write key matching any table entry; read-read matches SHALL NOT conflict.
REQ-012 On the first conflict, the scan SHALL stop and the FSM SHALL enter REJECT; the lowest-index matching entry's owner SHALL go to conflicting_id.
REQ-013 A clean scan SHALL take exactly 2*DEPS cycles and then enter COMMIT.
REQ-014 REJECT SHALL last 1 cycle with has_conflict=1, table and count unchanged, then return to IDLE.
REQ-015 COMMIT SHALL write each nonzero key to the next free entry (key, is_write, owner), one per cycle over 2*DEPS cycles; zero keys SHALL be skipped without writing.
REQ-016 ACCEPT SHALL last 1 cycle: accept_valid=1, accepted_id=latched ID, batch_count+1.
REQ-017 After ACCEPT, the FSM SHALL go to SEAL if batch_count==MAX_TXN or free entries < 2*DEPS, else to IDLE.
REQ-018 batch_seal sampled in IDLE with batch_count>0 SHALL enter SEAL; with batch_count==0 it SHALL be ignored; in other states it SHALL be held pending until IDLE.
REQ-019 SEAL SHALL hold batch_valid=1 and batch_count stable until batch_ready=1.
REQ-020 On the batch_ready cycle in SEAL, all entries SHALL be invalidated, count and fill pointer cleared, and the FSM SHALL return to IDLE next cycle.
REQ-021 Duplicate keys within one transaction SHALL NOT conflict with each other, since the table holds only previously admitted transactions.
REQ-022 Minimum admit latency, capture to accept_valid, SHALL be 4*DEPS+1 cycles.
REQ-023 accepted_id and conflicting_id SHALL hold their last values between pulses.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, clear all entry valid bits, count, fill pointer and pending seal, and drive accept_valid=0, has_conflict=0, batch_valid=0, accepted_id=0, conflicting_id=0.
REQ-025 Reset during CHECK, COMMIT or SEAL SHALL discard the in-flight transaction or batch with no output pulse.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the table-entry struct {valid, is_write, key, owner}, and the default DEPS, KEY_W, TABLE_DEPTH and MAX_TXN.
REQ-027 The parallel match and priority encode SHALL be a sub-module, key_table_cam, returning hit, hit_index and hit_owner.

Verification
REQ-028 Empty batch, txn 0xA with R{0x10}, W{0x20} -> accept_valid at capture+17 cycles (DEPS=4), accepted_id=0xA, batch_count=1.
REQ-029 Then txn 0xB with R{0x20} -> has_conflict at capture+2 (first key hits, REJECT next cycle), conflicting_id=0xA, batch_count stays 1.
REQ-030 Then txn 0xC with R{0x10} -> accepted (read-read), batch_count=2.
REQ-031 16 disjoint single-key txns -> 16th ACCEPT followed by batch_valid=1, batch_count=16; batch_ready held low 5 cycles, then high -> IDLE, count 0, key 0x10 then admissible.
REQ-032 batch_seal pulsed during CHECK of txn 0xD -> 0xD completes, then SEAL; batch_seal in IDLE with count 0 -> no batch_valid.
REQ-033 rst asserted mid-COMMIT -> no accept_valid, and a prior key no longer conflicts afterward.
